alu_rr_scheduler: RTL and testbench

//  Shares the single 32-bit add/sub ALU between NUM_REQ requesters. Round-robin grant, operand

---
 rtl/alu_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 39 +++
 rtl/alu_rr_scheduler.sv | 110 +++++++++++
 tb/tb_alu_rr_scheduler.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op codes, scheduler state encoding and data width
//
// Purpose: common definitions for the shared add/sub ALU and its round-robin
//          scheduler.
// Contents:
//   ALU_WIDTH   default operand/result width
//   ALU_OP_ADD  select value for a + b
//   ALU_OP_SUB  select value for a - b
//   sch_state_t scheduler FSM states (IDLE -> EXEC -> RESP -> IDLE)
package alu_pkg;

  localparam int   ALU_WIDTH  = 32;
  localparam logic ALU_OP_ADD = 1'b0;
  localparam logic ALU_OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    SCH_IDLE = 2'd0,
    SCH_EXEC = 2'd1,
    SCH_RESP = 2'd2
  } sch_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at a pointer
//
// Purpose: picks the first asserted request at or after ptr, wrapping around.
//          No state; the owner keeps the pointer register.
// Ports:
//   req          in   NUM_REQ  request vector
//   ptr          in   ID_W     highest-priority index for this pick
//   grant        out  NUM_REQ  one-hot grant (all zero when no request)
//   grant_idx    out  ID_W     encoded index of grant
//   grant_valid  out  1        some request was granted
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_valid
);

  always_comb begin
    int idx;
    idx         = 0;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    // Walk outward from ptr; the first hit wins and masks the rest.
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = (int'(ptr) + off) % NUM_REQ;
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = ID_W'(idx);
        grant[idx]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// rtl/alu_rr_scheduler.sv - round-robin sharing of one external add/sub ALU
//
// Purpose: grants one requester at a time, latches its operands into the
//          registers that feed the external ALU, captures the result and holds
//          it as a response until the consumer accepts it.
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   req_valid/a/b/sel     per-requester op (packed, slice i = [i*WIDTH +: WIDTH])
//   req_ready             one-hot accept strobe, only in IDLE
//   alu_a/alu_b/alu_sel   registered operands to the external ALU
//   alu_out               result from the external ALU
//   rsp_valid/id/data     held response
//   rsp_ready             consumer accepts response
module alu_rr_scheduler
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = ALU_WIDTH,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_sel,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic                     alu_sel,
  input  logic [WIDTH-1:0]         alu_out,
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_data,
  input  logic                     rsp_ready
);

  sch_state_t         state, state_nxt;
  logic [ID_W-1:0]    rr_ptr;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_valid;
  logic               accept;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req         (req_valid),
    .ptr         (rr_ptr),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= SCH_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SCH_IDLE: if (accept)    state_nxt = SCH_EXEC;
      SCH_EXEC:                state_nxt = SCH_RESP;
      SCH_RESP: if (rsp_ready) state_nxt = SCH_IDLE;
      default:                 state_nxt = SCH_IDLE;
    endcase
  end

  // Grants are masked while reset is high so nothing is accepted into a
  // pipeline that is about to be cleared.
  always_comb begin
    req_ready = '0;
    accept    = 1'b0;
    if (state == SCH_IDLE && !reset && grant_valid) begin
      req_ready = grant;
      accept    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      if (accept) begin
        alu_a   <= req_a[int'(grant_idx)*WIDTH +: WIDTH];
        alu_b   <= req_b[int'(grant_idx)*WIDTH +: WIDTH];
        alu_sel <= req_sel[grant_idx];
        // rsp_id can move here: rsp_valid is low until the result lands.
        rsp_id  <= grant_idx;
        rr_ptr  <= (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
      end
      if (state == SCH_EXEC) begin
        rsp_data  <= alu_out;
        rsp_valid <= 1'b1;
      end
      if (state == SCH_RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// tb/tb_alu_rr_scheduler.sv - self-checking bench for alu_rr_scheduler
module tb_alu_rr_scheduler;
  import alu_pkg::*;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0]   req_sel;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   alu_a, alu_b, alu_out;
  logic           alu_sel;
  logic           rsp_valid;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_data;
  logic           rsp_ready;

  int checks = 0;
  int errors = 0;
  int m_ptr  = 0;

  logic [W-1:0] op_a [N];
  logic [W-1:0] op_b [N];
  logic         op_s [N];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < N; gi++) begin : g_pack
    assign req_a[gi*W +: W] = op_a[gi];
    assign req_b[gi*W +: W] = op_b[gi];
    assign req_sel[gi]      = op_s[gi];
  end

  // External ALU
  assign alu_out = (alu_sel == ALU_OP_SUB) ? alu_a - alu_b : alu_a + alu_b;

  alu_rr_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sel   (req_sel),
    .req_ready (req_ready),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready)
  );

  function automatic int model_pick(input logic [N-1:0] v, input int p);
    for (int off = 0; off < N; off++) begin
      if (v[(p + off) % N]) return (p + off) % N;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] model_result(input int i);
    logic [W-1:0] r;
    r = op_s[i] ? op_a[i] - op_b[i] : op_a[i] + op_b[i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    m_ptr = 0;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      case ($urandom_range(0, 3))
        0:       op_a[i] = 32'hFFFF_FFFF;
        1:       op_a[i] = 32'h0;
        default: op_a[i] = $urandom;
      endcase
      op_b[i] = ($urandom_range(0, 3) == 0) ? 32'h1 : $urandom;
      op_s[i] = 1'($urandom_range(0, 1));
    end
  endtask

  // Waits for a grant, steps through the accept edge and then waits for
  // rsp_valid. Returns what it observed; callers do the checking.
  task automatic run_op(input bit drop, output logic [N-1:0] g, output int gap,
                        output int lat, output logic [1:0] id,
                        output logic [W-1:0] data, output bit ok);
    int gidx;
    g = '0; gap = 0; lat = 0; id = '0; data = '0; ok = 1'b0; gidx = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (req_ready != '0) begin
        g  = req_ready;
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      gap++;
    end
    if (!ok) return;
    for (int i = 0; i < N; i++) if (g[i]) gidx = i;
    tick();
    if (drop) req_valid[gidx] = 1'b0;
    lat = 1;
    ok  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid) begin
        id   = rsp_id;
        data = rsp_data;
        ok   = 1'b1;
        break;
      end
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    rsp_ready = 1'b1;
    rand_ops();
    req_valid = '1;
    tick();
    checks++;
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    tick();
    reset     = 1'b0;
    req_valid = '0;
    m_ptr     = 0;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (rsp_id !== 2'd0)    begin errors++; $display("FAIL reset_rsp_id: got %0d expected 0", rsp_id); end
    checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data: got %h expected 0", rsp_data); end
    checks++; if (alu_a !== 32'h0)    begin errors++; $display("FAIL reset_alu_a: got %h expected 0", alu_a); end
    checks++; if (alu_b !== 32'h0)    begin errors++; $display("FAIL reset_alu_b: got %h expected 0", alu_b); end
    checks++; if (alu_sel !== 1'b0)   begin errors++; $display("FAIL reset_alu_sel: got %b expected 0", alu_sel); end
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL idle_req_ready: got %b expected 0000", req_ready); end
  endtask

  task automatic test_single_add();
    logic [N-1:0] g; int gap, lat; logic [1:0] id; logic [W-1:0] d; bit ok;
    op_a[0] = 32'd5; op_b[0] = 32'd7; op_s[0] = ALU_OP_ADD;
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    run_op(1'b1, g, gap, lat, id, d, ok);
    checks++; if (!ok)          begin errors++; $display("FAIL add_timeout: got no response expected one"); end
    checks++; if (g !== 4'b0001) begin errors++; $display("FAIL add_grant: got %b expected 0001", g); end
    checks++; if (lat !== 2)     begin errors++; $display("FAIL add_latency: got %0d expected 2", lat); end
    checks++; if (id !== 2'd0)   begin errors++; $display("FAIL add_id: got %0d expected 0", id); end
    checks++; if (d !== 32'd12)  begin errors++; $display("FAIL add_data: got %0d expected 12", d); end
    m_ptr = 1;
    tick();
  endtask

  task automatic test_sub_wrap();
    logic [N-1:0] g; int gap, lat; logic [1:0] id; logic [W-1:0] d; bit ok;
    op_a[2] = 32'h0; op_b[2] = 32'h1; op_s[2] = ALU_OP_SUB;
    req_valid = 4'b0100;
    run_op(1'b1, g, gap, lat, id, d, ok);
    checks++; if (!ok || g !== 4'b0100) begin errors++; $display("FAIL sub_grant: got %b expected 0100", g); end
    checks++; if (id !== 2'd2)          begin errors++; $display("FAIL sub_id: got %0d expected 2", id); end
    checks++; if (d !== 32'hFFFF_FFFF)  begin errors++; $display("FAIL sub_wrap_data: got %h expected ffffffff", d); end
    tick();
    op_a[2] = 32'hFFFF_FFFF; op_b[2] = 32'h1; op_s[2] = ALU_OP_ADD;
    req_valid = 4'b0100;
    run_op(1'b1, g, gap, lat, id, d, ok);
    checks++; if (!ok || g !== 4'b0100) begin errors++; $display("FAIL add_wrap_grant: got %b expected 0100", g); end
    checks++; if (d !== 32'h0)          begin errors++; $display("FAIL add_wrap_data: got %h expected 0", d); end
    m_ptr = 3;
    tick();
  endtask

  task automatic test_contention();
    logic [N-1:0] g; int gap, lat; logic [1:0] id; logic [W-1:0] d; bit ok;
    int order [5] = '{0, 1, 2, 3, 0};
    int exp_i;
    logic [W-1:0] exp_d;
    do_reset();
    rand_ops();
    req_valid = '1;
    for (int k = 0; k < 5; k++) begin
      exp_i = model_pick(req_valid, m_ptr);
      exp_d = model_result(exp_i);
      run_op(1'b0, g, gap, lat, id, d, ok);
      checks++; if (!ok || g !== N'(1 << order[k])) begin errors++; $display("FAIL cont_grant%0d: got %b expected %b", k, g, N'(1 << order[k])); end
      checks++; if (id !== 2'(exp_i)) begin errors++; $display("FAIL cont_id%0d: got %0d expected %0d", k, id, exp_i); end
      checks++; if (d !== exp_d)      begin errors++; $display("FAIL cont_data%0d: got %h expected %h", k, d, exp_d); end
      if (k > 0) begin
        checks++; if (gap !== 1 || lat !== 2) begin errors++; $display("FAIL cont_rate%0d: got gap %0d lat %0d expected gap 1 lat 2", k, gap, lat); end
      end
      m_ptr = (exp_i + 1) % N;
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_backpressure();
    logic [N-1:0] g; int gap, lat; logic [1:0] id; logic [W-1:0] d; bit ok;
    logic [W-1:0] exp0, exp1;
    do_reset();
    rand_ops();
    exp0 = model_result(0);
    exp1 = model_result(1);
    req_valid = 4'b0011;
    rsp_ready = 1'b0;
    run_op(1'b1, g, gap, lat, id, d, ok);
    checks++; if (!ok || g !== 4'b0001 || lat !== 2) begin errors++; $display("FAIL bp_first: got grant %b lat %0d expected 0001 lat 2", g, lat); end
    m_ptr = 1;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== exp0 || req_ready !== 4'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: got v%b id%0d d%h rdy%b expected v1 id0 d%h rdy0000", k, rsp_valid, rsp_id, rsp_data, req_ready, exp0);
      end
    end
    rsp_ready = 1'b1;
    tick();
    #1;
    checks++; if (rsp_valid !== 1'b0)     begin errors++; $display("FAIL bp_release: got rsp_valid %b expected 0", rsp_valid); end
    checks++; if (req_ready !== 4'b0010)  begin errors++; $display("FAIL bp_next_grant: got %b expected 0010", req_ready); end
    run_op(1'b1, g, gap, lat, id, d, ok);
    checks++; if (!ok || g !== 4'b0010 || id !== 2'd1 || d !== exp1) begin errors++; $display("FAIL bp_second: got g%b id%0d d%h expected 0010 id1 d%h", g, id, d, exp1); end
    m_ptr = 2;
    tick();
    req_valid = '0;
  endtask

  task automatic test_reset_mid_op();
    logic [N-1:0] g; int gap, lat; logic [1:0] id; logic [W-1:0] d; bit ok;
    logic [W-1:0] exp0;
    do_reset();
    rand_ops();
    op_a[2] = 32'hA5A5_0001; op_s[2] = ALU_OP_SUB;
    exp0 = model_result(0);
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL mid_grant: got %b expected 0100", req_ready); end
    tick();
    req_valid = 4'b0000;
    reset     = 1'b1;
    req_valid = '1;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL mid_ready_in_reset: got %b expected 0000", req_ready); end
    tick();
    reset = 1'b0;
    m_ptr = 0;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_data !== 32'h0 || alu_a !== 32'h0 || alu_sel !== 1'b0) begin
      errors++;
      $display("FAIL mid_cleared: got v%b id%0d d%h a%h s%b expected all 0", rsp_valid, rsp_id, rsp_data, alu_a, alu_sel);
    end
    run_op(1'b1, g, gap, lat, id, d, ok);
    checks++; if (!ok || g !== 4'b0001 || lat !== 2 || id !== 2'd0 || d !== exp0) begin errors++; $display("FAIL mid_after: got g%b lat%0d id%0d d%h expected 0001 lat2 id0 d%h", g, lat, id, d, exp0); end
    m_ptr = 1;
    tick();
    req_valid = '0;
  endtask

  task automatic test_pointer_skip();
    logic [N-1:0] g; int gap, lat; logic [1:0] id; logic [W-1:0] d; bit ok;
    logic [N-1:0] exp_g [3] = '{4'b1000, 4'b0010, 4'b1000};
    logic [W-1:0] exp_d;
    rand_ops();
    rsp_ready = 1'b1;
    req_valid = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      exp_d = model_result(model_pick(req_valid, m_ptr));
      run_op(1'b1, g, gap, lat, id, d, ok);
      checks++; if (!ok || g !== exp_g[k] || d !== exp_d) begin errors++; $display("FAIL skip%0d: got g%b d%h expected %b d%h", k, g, d, exp_g[k], exp_d); end
      m_ptr = (model_pick(g, 0) + 1) % N;
      if (k == 0) req_valid = 4'b1010;
      tick();
    end
    req_valid = '0;
  endtask

  task automatic test_random();
    logic [N-1:0] g; int gap, lat; logic [1:0] id; logic [W-1:0] d; bit ok;
    logic [N-1:0] v;
    int exp_i, hold;
    logic [W-1:0] exp_d;
    for (int k = 0; k < 40; k++) begin
      rand_ops();
      v         = N'($urandom_range(1, (1 << N) - 1));
      exp_i     = model_pick(v, m_ptr);
      exp_d     = model_result(exp_i);
      req_valid = v;
      rsp_ready = 1'b0;
      run_op(1'b1, g, gap, lat, id, d, ok);
      checks++;
      if (!ok || g !== N'(1 << exp_i) || lat !== 2 || id !== 2'(exp_i) || d !== exp_d) begin
        errors++;
        $display("FAIL rand%0d: got g%b lat%0d id%0d d%h expected g%b lat2 id%0d d%h", k, g, lat, id, d, N'(1 << exp_i), exp_i, exp_d);
      end
      m_ptr = (exp_i + 1) % N;
      hold  = $urandom_range(0, 3);
      for (int h = 0; h < hold; h++) begin
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== exp_d || req_ready !== 4'b0) begin
          errors++;
          $display("FAIL rand_hold%0d: got v%b d%h rdy%b expected v1 d%h rdy0000", k, rsp_valid, rsp_data, req_ready, exp_d);
        end
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      req_valid = '0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      op_a[i] = '0; op_b[i] = '0; op_s[i] = 1'b0;
    end
    test_reset();
    test_single_add();
    test_sub_wrap();
    test_contention();
    test_backpressure();
    test_reset_mid_op();
    test_pointer_skip();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
